// File: rtl/tx_arb.sv
// tx_arb: two-port packet arbiter merging port A (packet generator / test
// traffic) and port B (loopback) onto one registered output stream.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   cfg_prio_b          1 = B has strict priority, 0 = round-robin A/B
//   pause_on            1 = A is not granted a new packet (checked in IDLE only)
//   a_* / b_*           source ports: req, valid, sop, eop, data[31:0], mod[1:0],
//                       ready (output)
//   out_rdy             downstream enable; no beat is issued while it is 0
//   int_*_o             merged stream, 1-cycle registered copy of accepted beats
//   grant_o             one-hot owner: bit0 = A, bit1 = B, 00 when unowned
//   pkt_cnt_a/_b        completed-packet counters, wrap at all-ones
//   dbg_state_o         current FSM state (IDLE=0, XFER_A=1, XFER_B=2, GAP=3)
//
// Handshake: a beat moves from the owning port when its valid and ready are
// both 1 on a rising edge. ready is out_rdy gated by ownership, so it never
// depends on valid; valid may stay high indefinitely while ready is 0.
module tx_arb #(
  parameter int IPG_CYCLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_prio_b,
  input  logic             pause_on,
  input  logic             a_req,
  input  logic             a_valid,
  input  logic             a_sop,
  input  logic             a_eop,
  input  logic [31:0]      a_data,
  input  logic [1:0]       a_mod,
  output logic             a_ready,
  input  logic             b_req,
  input  logic             b_valid,
  input  logic             b_sop,
  input  logic             b_eop,
  input  logic [31:0]      b_data,
  input  logic [1:0]       b_mod,
  output logic             b_ready,
  input  logic             out_rdy,
  output logic             int_valid_o,
  output logic             int_sop_o,
  output logic             int_eop_o,
  output logic [31:0]      int_data_o,
  output logic [1:0]       int_mod_o,
  output logic [1:0]       grant_o,
  output logic [CNT_W-1:0] pkt_cnt_a,
  output logic [CNT_W-1:0] pkt_cnt_b,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER_A = 2'd1,
    XFER_B = 2'd2,
    GAP    = 2'd3
  } state_e;

  // Gap counter holds IPG_CYCLES-1 down to 0.
  localparam int GW = (IPG_CYCLES > 2) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (IPG_CYCLES > 0) ? GW'(IPG_CYCLES - 1) : '0;

  state_e            state_q;
  logic              last_b_q;
  logic [GW-1:0]     gap_q;
  logic              valid_q;
  logic              sop_q;
  logic              eop_q;
  logic [31:0]       data_q;
  logic [1:0]        mod_q;
  logic [CNT_W-1:0]  cnt_a_q;
  logic [CNT_W-1:0]  cnt_b_q;

  logic        a_elig;
  logic        b_elig;
  logic        pick_b;
  logic        xfer_a;
  logic        xfer_b;
  logic        xfer;
  logic        xfer_eop;
  logic        sel_sop;
  logic        sel_eop;
  logic [31:0] sel_data;
  logic [1:0]  sel_mod;

  always_comb begin
    a_elig = a_req & ~pause_on;
    b_elig = b_req;
    // B wins when it is the only candidate, when it has strict priority,
    // or on a round-robin tie when A was granted last.
    pick_b = b_elig & (~a_elig | cfg_prio_b | ~last_b_q);

    xfer_a   = (state_q == XFER_A) & a_valid & out_rdy;
    xfer_b   = (state_q == XFER_B) & b_valid & out_rdy;
    xfer     = xfer_a | xfer_b;
    xfer_eop = (xfer_a & a_eop) | (xfer_b & b_eop);

    sel_sop  = xfer_b ? b_sop  : a_sop;
    sel_eop  = xfer_b ? b_eop  : a_eop;
    sel_data = xfer_b ? b_data : a_data;
    sel_mod  = xfer_b ? b_mod  : a_mod;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      data_q   <= '0;
      mod_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      // Output register: qualifiers drop when nothing transfers, payload holds.
      valid_q <= xfer;
      sop_q   <= xfer & sel_sop;
      eop_q   <= xfer & sel_eop;
      if (xfer) begin
        data_q <= sel_data;
        mod_q  <= sel_mod;
      end

      case (state_q)
        IDLE: begin
          if (a_elig | b_elig) begin
            state_q  <= pick_b ? XFER_B : XFER_A;
            last_b_q <= pick_b;
          end
        end
        XFER_A, XFER_B: begin
          if (xfer_eop) begin
            if (xfer_a) cnt_a_q <= cnt_a_q + CNT_W'(1);
            else        cnt_b_q <= cnt_b_q + CNT_W'(1);
            if (IPG_CYCLES == 0) begin
              state_q <= IDLE;
            end else begin
              state_q <= GAP;
              gap_q   <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ready     = (state_q == XFER_A) & out_rdy;
  assign b_ready     = (state_q == XFER_B) & out_rdy;
  assign grant_o     = {state_q == XFER_B, state_q == XFER_A};
  assign int_valid_o = valid_q;
  assign int_sop_o   = sop_q;
  assign int_eop_o   = eop_q;
  assign int_data_o  = data_q;
  assign int_mod_o   = mod_q;
  assign pkt_cnt_a   = cnt_a_q;
  assign pkt_cnt_b   = cnt_b_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tx_arb.sv
// tb_tx_arb: self-checking bench for tx_arb. Two packet sources feed the
// DUT from beat queues; a packet-level reference model (owner / gap countdown
// / last winner) predicts grants, readies, the output register and the
// packet counters each cycle, and a scoreboard checks the merged beat order.
// The counter width is reduced so that counter wrap is reached quickly.
module tb_tx_arb;

  localparam int IPG   = 3;
  localparam int CNT_W = 6;

  logic             clk;
  logic             rst;
  logic             cfg_prio_b;
  logic             pause_on;
  logic             a_req, a_valid, a_sop, a_eop, a_ready;
  logic [31:0]      a_data;
  logic [1:0]       a_mod;
  logic             b_req, b_valid, b_sop, b_eop, b_ready;
  logic [31:0]      b_data;
  logic [1:0]       b_mod;
  logic             out_rdy;
  logic             int_valid_o, int_sop_o, int_eop_o;
  logic [31:0]      int_data_o;
  logic [1:0]       int_mod_o;
  logic [1:0]       grant_o;
  logic [CNT_W-1:0] pkt_cnt_a, pkt_cnt_b;
  logic [1:0]       dbg_state_o;

  tx_arb #(.IPG_CYCLES(IPG), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_prio_b(cfg_prio_b), .pause_on(pause_on),
    .a_req(a_req), .a_valid(a_valid), .a_sop(a_sop), .a_eop(a_eop),
    .a_data(a_data), .a_mod(a_mod), .a_ready(a_ready),
    .b_req(b_req), .b_valid(b_valid), .b_sop(b_sop), .b_eop(b_eop),
    .b_data(b_data), .b_mod(b_mod), .b_ready(b_ready),
    .out_rdy(out_rdy),
    .int_valid_o(int_valid_o), .int_sop_o(int_sop_o), .int_eop_o(int_eop_o),
    .int_data_o(int_data_o), .int_mod_o(int_mod_o),
    .grant_o(grant_o), .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Beat format: {sop, eop, mod[1:0], data[31:0]}
  logic [35:0] a_q[$];
  logic [35:0] b_q[$];
  logic [35:0] exp_q[$];
  int          grant_log[$];
  int          prev_grant = 0;
  int          dut_beats = 0;

  // knobs
  logic k_rst, k_prio, k_pause;
  int   k_rdy_pct, k_valid_pct, k_gen_pct;

  // ---------------- reference model ----------------
  // owner: 0 = nobody, 1 = A, 2 = B, 3 = inter-packet gap
  bit               m_known = 0;
  int               m_owner;
  int               m_gap_left;
  bit               m_last_b;
  bit               m_v, m_sop, m_eop;
  logic [31:0]      m_data;
  logic [1:0]       m_mod;
  logic [CNT_W-1:0] m_cnt_a, m_cnt_b;

  function automatic logic [35:0] mk(input bit sop, input bit eop,
                                     input logic [1:0] mod, input logic [31:0] data);
    return {sop, eop, mod, data};
  endfunction

  task automatic push_pkt(input int port, input int len);
    logic [35:0] beat;
    for (int i = 0; i < len; i++) begin
      beat = mk(i == 0, i == len - 1,
                (i == len - 1) ? 2'($urandom_range(3)) : 2'd0, $urandom);
      if (port == 0) a_q.push_back(beat);
      else           b_q.push_back(beat);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    logic [35:0] junk;
    rst        = k_rst;
    cfg_prio_b = k_prio;
    pause_on   = k_pause;
    out_rdy    = ($urandom_range(99) < k_rdy_pct);
    if (k_gen_pct > 0 && a_q.size() == 0 && $urandom_range(99) < k_gen_pct)
      push_pkt(0, $urandom_range(1, 4));
    if (k_gen_pct > 0 && b_q.size() == 0 && $urandom_range(99) < k_gen_pct)
      push_pkt(1, $urandom_range(1, 4));
    a_req   = (a_q.size() != 0);
    a_valid = a_req && ($urandom_range(99) < k_valid_pct);
    junk    = {$urandom, $urandom};
    {a_sop, a_eop, a_mod, a_data} = a_req ? a_q[0] : junk;
    b_req   = (b_q.size() != 0);
    b_valid = b_req && ($urandom_range(99) < k_valid_pct);
    junk    = {$urandom, $urandom};
    {b_sop, b_eop, b_mod, b_data} = b_req ? b_q[0] : junk;
  endtask

  // ---------------- checker ----------------
  task automatic check_outputs();
    logic [35:0] beat;
    int exp_grant;
    if (!m_known) return;
    exp_grant = (m_owner == 1) ? 1 : (m_owner == 2) ? 2 : 0;
    chk("grant", grant_o, exp_grant);
    chk("a_ready", a_ready, (m_owner == 1) && out_rdy);
    chk("b_ready", b_ready, (m_owner == 2) && out_rdy);
    chk("int_valid", int_valid_o, m_v);
    chk("int_sop", int_sop_o, m_sop);
    chk("int_eop", int_eop_o, m_eop);
    chk("int_data", int_data_o, m_data);
    chk("int_mod", int_mod_o, m_mod);
    chk("pkt_cnt_a", pkt_cnt_a, m_cnt_a);
    chk("pkt_cnt_b", pkt_cnt_b, m_cnt_b);
    if (int_valid_o === 1'b1) begin
      dut_beats++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_beat", 1, 0);
      end else begin
        beat = exp_q.pop_front();
        chk("sb_beat", {int_sop_o, int_eop_o, int_mod_o, int_data_o}, beat);
      end
    end
    if (grant_o != 2'b00 && prev_grant == 0) grant_log.push_back(int'(grant_o));
    prev_grant = int'(grant_o);
  endtask

  // Predict the effect of the coming rising edge from the driven inputs.
  task automatic model_update();
    bit acc_a, acc_b;
    logic [35:0] beat;
    if (rst) begin
      m_known = 1; m_owner = 0; m_gap_left = 0; m_last_b = 1;
      m_v = 0; m_sop = 0; m_eop = 0; m_data = '0; m_mod = '0;
      m_cnt_a = '0; m_cnt_b = '0;
      a_q.delete(); b_q.delete(); exp_q.delete();
      return;
    end
    acc_a = (m_owner == 1) && a_valid && out_rdy;
    acc_b = (m_owner == 2) && b_valid && out_rdy;
    m_v = acc_a || acc_b;
    m_sop = 0; m_eop = 0;
    if (acc_a || acc_b) begin
      beat = acc_a ? a_q.pop_front() : b_q.pop_front();
      exp_q.push_back(beat);
      {m_sop, m_eop, m_mod, m_data} = beat;
    end
    case (m_owner)
      0: begin
        if ((a_req && !pause_on) || b_req) begin
          if (a_req && !pause_on && b_req)
            m_owner = cfg_prio_b ? 2 : (m_last_b ? 1 : 2);
          else
            m_owner = b_req ? 2 : 1;
          m_last_b = (m_owner == 2);
        end
      end
      1, 2: begin
        if ((acc_a || acc_b) && m_eop) begin
          if (acc_a) m_cnt_a++;
          else       m_cnt_b++;
          if (IPG > 0) begin m_owner = 3; m_gap_left = IPG; end
          else m_owner = 0;
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_owner = 0;
      end
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_inputs();
      @(negedge clk);
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    k_rst = 1; run(1); k_rst = 0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && n < budget) begin
      run(1); n++;
    end
    if (n >= budget) chk({tag, "_timeout"}, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  int rr_exp[4] = '{1, 2, 1, 2};
  int n;

  initial begin
    k_rst = 1; k_prio = 0; k_pause = 0;
    k_rdy_pct = 100; k_valid_pct = 100; k_gen_pct = 0;
    run(2);
    k_rst = 0;
    run(1);

    // A-only 4-beat packet, then the gap.
    dut_beats = 0;
    a_q.push_back(mk(1, 0, 2'd0, 32'h11111111));
    a_q.push_back(mk(0, 0, 2'd0, 32'h22222222));
    a_q.push_back(mk(0, 0, 2'd0, 32'h33333333));
    a_q.push_back(mk(0, 1, 2'd2, 32'h44444444));
    wait_drain("single_pkt", 50);
    run(6);
    chk("single_pkt_cnt_a", pkt_cnt_a, 1);
    chk("single_pkt_beats", dut_beats, 4);

    // Round-robin tie with 1-beat packets.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin push_pkt(0, 1); push_pkt(1, 1); end
    wait_drain("rr", 200);
    run(5);
    for (int i = 0; i < 4; i++)
      chk("rr_order", (grant_log.size() > i) ? grant_log[i] : 0, rr_exp[i]);

    // Strict B priority.
    k_prio = 1;
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin push_pkt(0, 1); push_pkt(1, 1); end
    wait_drain("prio_b", 200);
    run(5);
    for (int i = 0; i < 3; i++)
      chk("prio_b_order", (grant_log.size() > i) ? grant_log[i] : 0, 2);
    k_prio = 0;

    // Pause holds A off entirely.
    do_reset();
    grant_log.delete();
    k_pause = 1;
    push_pkt(0, 2);
    run(30);
    chk("pause_no_grant", grant_log.size(), 0);
    chk("pause_pkt_pending", a_q.size(), 2);
    k_pause = 0;

    // Pause raised during beat 2 does not cut the packet.
    do_reset();
    grant_log.delete();
    dut_beats = 0;
    push_pkt(0, 4);
    n = 0;
    while (a_q.size() > 3 && n < 50) begin run(1); n++; end
    if (n >= 50) chk("pause_mid_timeout", 1, 0);
    k_pause = 1;
    wait_drain("pause_mid", 50);
    run(5);
    chk("pause_mid_beats", dut_beats, 4);
    push_pkt(0, 1);
    run(30);
    chk("pause_after_grants", grant_log.size(), 1);
    k_pause = 0;
    wait_drain("pause_release", 50);

    // Reset in the middle of a packet.
    do_reset();
    push_pkt(0, 4);
    n = 0;
    while (a_q.size() > 2 && n < 50) begin run(1); n++; end
    if (n >= 50) chk("rst_mid_timeout", 1, 0);
    do_reset();
    chk("rst_mid_grant", grant_o, 0);
    chk("rst_mid_valid", int_valid_o, 0);
    chk("rst_mid_data", int_data_o, 0);
    chk("rst_mid_a_ready", a_ready, 0);
    run(10);

    // Counter wrap: 70 packets on a 6-bit counter.
    do_reset();
    for (int i = 0; i < 70; i++) push_pkt(0, 1);
    wait_drain("wrap", 1000);
    run(5);
    chk("cnt_wrap", pkt_cnt_a, 70 % (1 << CNT_W));

    // Randomised traffic with stalls, pause, priority changes and resets.
    do_reset();
    for (int blk = 0; blk < 30; blk++) begin
      k_prio      = 1'($urandom_range(1));
      k_pause     = ($urandom_range(3) == 0);
      k_rdy_pct   = $urandom_range(40, 100);
      k_valid_pct = $urandom_range(40, 100);
      k_gen_pct   = $urandom_range(10, 60);
      for (int cyc = 0; cyc < 100; cyc++) begin
        k_rst = (cyc == 50) && (blk % 7 == 3);
        run(1);
      end
    end
    k_rst = 0; k_pause = 0; k_gen_pct = 0;
    wait_drain("final", 500);
    run(10);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_arb.md
TX_ARB -- requirements
Module: tx_arb

Interface
REQ-001 Parameter IPG_CYCLES, default 3: idle cycles inserted after each packet's EOP beat before the next grant (0 = none).
REQ-002 Parameter CNT_W, default 16: width of the per-port packet counters.
REQ-003 clk  input  1  single clock for all logic; no other clock exists in the block.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 cfg_prio_b  input  1  1 = port B has strict priority; 0 = round-robin between A and B.
REQ-006 pause_on  input  1  1 = port A (test traffic) is not granted a new packet.
REQ-007 a_req  input  1  port A (packet generator) has a packet pending.
REQ-008 a_valid / a_sop / a_eop  input  1 each  port A beat valid, start-of-packet, end-of-packet.
REQ-009 a_data  input  32  port A beat data.
REQ-010 a_mod  input  2  port A count of invalid bytes in the EOP beat.
REQ-011 a_ready  output  1  port A beat accepted when a_valid & a_ready.
REQ-012 b_req, b_valid, b_sop, b_eop, b_data[31:0], b_mod[1:0], b_ready: port B (loopback) with the same meanings as port A.
REQ-013 out_rdy  input  1  downstream gearbox generator enable; a beat may only be issued while it is 1.
REQ-014 int_valid_o, int_sop_o, int_eop_o  output  1 each  merged stream beat qualifiers.
REQ-015 int_data_o  output  32  merged stream data.
REQ-016 int_mod_o  output  2  merged stream EOP byte modulus.
REQ-017 grant_o  output  2  one-hot current owner: bit0 = A, bit1 = B; 00 when no port owns the stream.
REQ-018 pkt_cnt_a, pkt_cnt_b  output  CNT_W each  count of packets completed per port.

Function
REQ-019 FSM states: IDLE, XFER_A, XFER_B, GAP.
REQ-020 Eligibility in IDLE:
- A is eligible when a_req=1 and pause_on=0.
- B is eligible when b_req=1.
REQ-021 Arbitration:
- Only one eligible port: IDLE moves to that port's XFER state on the next edge.
- Both eligible, cfg_prio_b=1: B is chosen.
- Both eligible, cfg_prio_b=0: the port not granted last is chosen.
- No eligible port: the FSM stays in IDLE.
REQ-022 Last-grant pointer: updates on every IDLE->XFER transition; resets to B, so A wins the first round-robin tie.
REQ-023 Ready signals: a_ready = out_rdy in XFER_A, 0 otherwise; b_ready = out_rdy in XFER_B, 0 otherwise; never 1 in IDLE or GAP.
REQ-024 Output register:
- A beat transfers when the owning port's valid and ready are both 1.
- On transfer, data/sop/eop/mod are registered onto int_*_o the next cycle with int_valid_o=1.
- Otherwise int_valid_o=0 and int_sop_o/int_eop_o=0; data and mod hold their last value.
- Latency is exactly 1 cycle.
REQ-025 Packet end:
- Transfer of an EOP beat ends ownership: XFER goes to GAP, or to IDLE when IPG_CYCLES=0.
- The owning pkt_cnt increments by 1 on that edge and wraps from all-ones to 0.
REQ-026 GAP: a counter loads IPG_CYCLES-1 on entry, decrements each cycle, and the FSM returns to IDLE when it reaches 0, giving exactly IPG_CYCLES GAP cycles.
REQ-027 pause_on is evaluated only in IDLE; asserting it mid-packet does not interrupt port A's packet.
REQ-028 Beats while out_rdy=0: no beat transfers and ownership holds; the owning port's valid may stay high indefinitely.
REQ-029 Beat validity: a beat with sop=1 during an ongoing packet, or an unrequested port's valid, is passed unmodified or ignored respectively; the block does not repair framing.
REQ-030 Requests while owned: a_req/b_req changes during XFER or GAP have no effect until IDLE.
REQ-031 grant_o = 01 in XFER_A, 10 in XFER_B, 00 in IDLE and GAP.

Reset
REQ-032 Reset applies on any cycle, including mid-packet, and overrides all other activity in that cycle.
REQ-033 Register values under reset:
- State = IDLE, last-grant = B, GAP counter = 0.
- int_valid_o = int_sop_o = int_eop_o = 0, int_data_o = 0, int_mod_o = 0.
- grant_o = 00, pkt_cnt_a = pkt_cnt_b = 0.
- a_ready = b_ready = 0.
REQ-034 A packet interrupted by reset is not resumed; the first grant after reset follows REQ-021 afresh.

Verification
REQ-035 A only, pause_on=0, out_rdy=1, 4-beat packet (data 0x11111111..0x44444444, mod=2) -> int_* replays the beats 1 cycle later; then 3 GAP cycles with grant_o=00; pkt_cnt_a=1.
REQ-036 a_req=b_req=1 held, cfg_prio_b=0, 1-beat packets -> grant order A,B,A,B; with cfg_prio_b=1 -> B,B,B.
REQ-037 pause_on=1 with a_req=1 -> A is never granted; pause_on raised during beat 2 of a 4-beat A packet -> all 4 beats are delivered, then A is held off.
REQ-038 out_rdy toggled 1,0,0,1 during XFER_B -> b_ready follows out_rdy; no duplicated or dropped beats; int_valid_o=0 on the stall cycles +1.
REQ-039 rst asserted on beat 2 of a packet -> next cycle all outputs are 0 and grant_o=00; pkt_cnt_a at 0xFFFF plus 1 packet (CNT_W=16) -> 0x0000.
